// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave endpoint, MSB first, full duplex.
// The received frame (128/192/256 bits) is delivered as one right-aligned block
// through a valid/ready port. tx_data is shifted back to the master on miso
// during the same frame. All SPI pins are oversampled in the clk domain.
//
// Handshake: rx_valid stays high and rx_data stays stable until a clk edge
// with rx_ready high. rx_valid drops on the next cycle, unless a new frame
// completes in that same cycle. In that case the new block replaces the old one.
module spi_slave_rx #(
  parameter int MAX_BITS    = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  input  logic [1:0]          size,
  input  logic [MAX_BITS-1:0] tx_data,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                frame_err,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int            CW   = $clog2(MAX_BITS + 2);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BITS);

  localparam logic [1:0] WAIT_HI = 2'd0;
  localparam logic [1:0] IDLE    = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [MAX_BITS-1:0]    rx_shift, tx_shift, tx_load, len_mask;
  logic [CW-1:0]          bitcnt, frame_len, start_len;
  logic                   start_ok;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign busy      = (state == SHIFT);
  assign state_dbg = state;

  // Synchronise the asynchronous SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Decode the frame length from size. The reserved code is flagged, not started.
  always_comb begin
    start_len = '0;
    start_ok  = 1'b1;
    case (size)
      2'b00:   start_len = CW'(128);
      2'b01:   start_len = CW'(192);
      2'b10:   start_len = CW'(256);
      default: start_ok  = 1'b0;
    endcase
  end

  // tx is left-aligned so that bit N-1 is always at the top of the shifter.
  // The received block is masked down to the frame length.
  assign tx_load  = tx_data << (MAXB - start_len);
  assign len_mask = {MAX_BITS{1'b1}} >> (MAXB - frame_len);

  // Frame FSM: start on cs fall, shift on sclk edges, deliver or reject on cs rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= WAIT_HI;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      bitcnt    <= '0;
      frame_len <= '0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        WAIT_HI: begin
          miso <= 1'b0;
          if (cs_s) state <= IDLE;
        end
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            if (start_ok) begin
              frame_len <= start_len;
              tx_shift  <= tx_load;
              miso      <= tx_load[MAX_BITS-1];
              bitcnt    <= '0;
              state     <= SHIFT;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            miso  <= 1'b0;
            if (bitcnt == frame_len) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= rx_shift & len_mask;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[MAX_BITS-2:0], mosi_s};
            if (bitcnt != frame_len + CW'(1)) bitcnt <= bitcnt + CW'(1);
          end else if (sclk_fall) begin
            // Zeros shift in from below, so miso returns to 0 after the last bit.
            tx_shift <= {tx_shift[MAX_BITS-2:0], 1'b0};
            miso     <= tx_shift[MAX_BITS-2];
          end
        end
        default: begin
          state <= WAIT_HI;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a directed SPI master driver, a scoreboard queue of
// expected rx blocks, and a monitor that pops the queue on each accepted block.
module tb_spi_slave_rx;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [1:0]   size = 2'b00;
  logic [W-1:0] tx_data = '0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b1;
  logic         frame_err;
  logic         busy;
  logic [1:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           err_cnt = 0;
  int           exp_err = 0;
  logic         prev_err = 1'b0;

  spi_slave_rx #(.MAX_BITS(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .size(size), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SPI master, mode 0, sclk = clk/8. MISO is captured just before each rising edge.
  // If rst_at is nonzero, reset is pulsed one clk after that rising edge.
  task automatic spi_xfer(input int npulses, input logic [W-1:0] mv, input int rst_at,
                          output logic [W-1:0] mcap);
    mcap = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < npulses; k++) begin
      mosi = mv[npulses-1-k];
      repeat (4) @(negedge clk);
      mcap = {mcap[W-2:0], miso};
      sclk = 1'b1;
      if (k + 1 == rst_at) begin
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_rx_data", rx_data, '0);
        chk("mid_reset_flags", {W'(rx_valid), W'(busy), W'(miso), W'(frame_err)}, '0);
        reset = 1'b1;
      end
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    mosi = 1'b0;
    cs_n = 1'b1;
  endtask

  task automatic check_err(input string nm);
    repeat (8) @(negedge clk);
    chk(nm, W'(err_cnt), W'(exp_err));
  endtask

  // Monitor: counts frame_err pulses and checks each accepted block against the queue.
  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #1;
    if (reset) begin
      if (frame_err) begin
        err_cnt++;
        n_cmp++;
        if (prev_err) begin
          n_fail++;
          $display("FAIL frame_err_width: got 2+ cycle pulse expected 1 cycle");
        end
      end
      prev_err = frame_err;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_block: got %h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_block", rx_data, e);
        end
      end
    end else begin
      prev_err = 1'b0;
    end
  end

  // Stimulus
  initial begin
    logic [W-1:0] cap;
    logic [W-1:0] f1;
    logic         bad;

    repeat (4) @(negedge clk);
    chk("reset_rx_data", rx_data, '0);
    chk("reset_flags", {W'(rx_valid), W'(busy), W'(miso), W'(frame_err), W'(state_dbg)}, '0);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    // T1: 128-bit frame. The upper tx bits are junk that must not reach miso.
    size    = 2'b00;
    tx_data = {{16{8'hFF}}, {16{8'hA5}}};
    exp_q.push_back({128'h0, 128'h00112233445566778899aabbccddeeff});
    spi_xfer(128, {128'h0, 128'h00112233445566778899aabbccddeeff}, 0, cap);
    @(negedge clk);
    @(negedge clk);
    chk("t1_valid_early", W'(rx_valid), W'(0));
    @(negedge clk);
    chk("t1_valid_latency", W'(rx_valid), W'(1));
    chk("t1_miso", cap, {128'h0, {16{8'hA5}}});
    check_err("t1_err");

    // T2: 256-bit frame with the consumer stalled for 20 cycles.
    size     = 2'b10;
    tx_data  = {32{8'h3C}};
    rx_ready = 1'b0;
    exp_q.push_back({4{64'h0123456789ABCDEF}});
    spi_xfer(256, {4{64'h0123456789ABCDEF}}, 0, cap);
    chk("t2_miso", cap, {32{8'h3C}});
    repeat (4) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rx_valid || rx_data !== {4{64'h0123456789ABCDEF}}) bad = 1'b1;
    end
    chk("t2_hold_stable", W'(bad), W'(0));
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drop", W'(rx_valid), W'(0));
    check_err("t2_err");

    // T3: short frame of 100 pulses with size=01.
    size = 2'b01;
    spi_xfer(100, {4{64'hFFFF0000FFFF0000}}, 0, cap);
    exp_err++;
    check_err("t3_err");
    chk("t3_no_valid", W'(rx_valid), W'(0));

    // T4: the reserved size must not start a frame.
    size = 2'b11;
    @(negedge clk);
    cs_n = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy || miso) bad = 1'b1;
    end
    chk("t4_no_shift", W'(bad), W'(0));
    cs_n = 1'b1;
    exp_err++;
    check_err("t4_err");
    chk("t4_no_valid", W'(rx_valid), W'(0));

    // T5: two back-to-back frames while stalled. The second frame is an overrun.
    size     = 2'b00;
    rx_ready = 1'b0;
    f1       = {128'h0, 128'hDEADBEEF00000000CAFEF00D12345678};
    exp_q.push_back(f1);
    spi_xfer(128, f1, 0, cap);
    repeat (6) @(negedge clk);
    spi_xfer(128, {128'h0, 128'h0F0E0D0C0B0A09080706050403020100}, 0, cap);
    exp_err++;
    check_err("t5_err");
    chk("t5_kept_first", rx_data, f1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);

    // T6: reset shortly after bit 64. The rest of the frame is ignored, then a clean frame follows.
    spi_xfer(128, {128'h0, {16{8'h77}}}, 64, cap);
    check_err("t6_err_abort");
    chk("t6_no_valid", W'(rx_valid), W'(0));
    exp_q.push_back({128'h0, 128'hFEDCBA98765432100123456789ABCDEF});
    repeat (6) @(negedge clk);
    spi_xfer(128, {128'h0, 128'hFEDCBA98765432100123456789ABCDEF}, 0, cap);
    repeat (3) @(negedge clk);
    check_err("t6_err_final");

    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
